// File: rtl/cr_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr_reset_seq_pkg
// Brief    : Shared types and helpers for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cr_reset_seq_pkg;

  // Sequencer states: domains held, stepping out of reset, running, draining.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } seq_state_e;

  // Domain index width; a single domain still needs a 1-bit index.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_DOM = 4;
  localparam int IDX_W       = calc_idx_w(DEF_NUM_DOM);

endpackage
`default_nettype wire

// File: rtl/cr_reset_seq_sync.sv
`default_nettype none
// ============================================================================
// Module   : cr_reset_seq_sync
// Brief    : Two-flop synchronizer, async active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cr_reset_seq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/cr_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cr_reset_sequencer
// Brief    : Quiesce-then-assert / staggered-release reset sequencer for a
//            group of datapath sub-domains.
// Revision : 1.0 - initial release
// ============================================================================
module cr_reset_sequencer
  import cr_reset_seq_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int DLY_W    = 8,
  parameter int MIN_HOLD = 16,
  parameter int QTMO     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst_req,
  input  logic [NUM_DOM*DLY_W-1:0] cfg_dly,
  output logic                     quiesce_req,
  input  logic                     quiesce_ack,
  output logic [NUM_DOM-1:0]       rst_out,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     qtmo_err
);

  localparam int DOM_IDX_W = calc_idx_w(NUM_DOM);
  localparam int HOLD_W    = $clog2(MIN_HOLD + 1);
  localparam int TMO_W     = $clog2(QTMO + 1);

  localparam logic [HOLD_W-1:0]    C_HOLD_LOAD = HOLD_W'(MIN_HOLD);
  localparam logic [TMO_W-1:0]     C_TMO_LOAD  = TMO_W'(QTMO);
  localparam logic [NUM_DOM-1:0]   C_ALL_RST   = {NUM_DOM{1'b1}};

  logic                 w_req_s;

  seq_state_e           r_state,   w_state_nxt;
  logic [HOLD_W-1:0]    r_hold,    w_hold_nxt;
  logic [DOM_IDX_W-1:0] r_idx,     w_idx_nxt;
  logic [DLY_W-1:0]     r_dcnt,    w_dcnt_nxt;
  logic [TMO_W-1:0]     r_tcnt,    w_tcnt_nxt;
  logic [NUM_DOM-1:0]   r_rst_out, w_rst_out_nxt;
  logic                 r_qreq,    w_qreq_nxt;
  logic                 r_err,     w_err_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic [DLY_W-1:0]     w_next_dly;

  cr_reset_seq_sync u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (soft_rst_req),
    .q   (w_req_s)
  );

  // Release gap of the domain following the current index.
  always_comb begin
    w_next_dly = '0;
    for (int i = 1; i < NUM_DOM; i++) begin
      if (int'(r_idx) + 1 == i) w_next_dly = cfg_dly[i*DLY_W +: DLY_W];
    end
  end

  // Next-state, counter and output decisions for the sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_idx_nxt     = r_idx;
    w_dcnt_nxt    = r_dcnt;
    w_tcnt_nxt    = r_tcnt;
    w_rst_out_nxt = r_rst_out;
    w_qreq_nxt    = r_qreq;
    w_err_nxt     = r_err;

    case (r_state)
      ST_HOLD: begin
        w_rst_out_nxt = C_ALL_RST;
        if (r_hold != '0) begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end else if (!w_req_s) begin
          w_state_nxt = ST_RELEASE;
          w_idx_nxt   = '0;
          w_dcnt_nxt  = cfg_dly[DLY_W-1:0];
        end
      end

      ST_RELEASE: begin
        // A renewed request aborts the release with no quiesce handshake.
        if (w_req_s) begin
          w_rst_out_nxt = C_ALL_RST;
          w_state_nxt   = ST_HOLD;
          w_hold_nxt    = C_HOLD_LOAD;
        end else if (r_dcnt == '0) begin
          w_rst_out_nxt[r_idx] = 1'b0;
          if (int'(r_idx) < NUM_DOM - 1) begin
            w_idx_nxt  = r_idx + DOM_IDX_W'(1);
            w_dcnt_nxt = w_next_dly;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_dcnt_nxt = r_dcnt - DLY_W'(1);
        end
      end

      ST_RUN: begin
        w_rst_out_nxt = '0;
        if (w_req_s) begin
          w_state_nxt = ST_QUIESCE;
          w_qreq_nxt  = 1'b1;
          w_tcnt_nxt  = C_TMO_LOAD;
        end
      end

      ST_QUIESCE: begin
        // Once entered, always finish asserting resets even if the request drops.
        if (quiesce_ack || (r_tcnt == '0)) begin
          w_rst_out_nxt = C_ALL_RST;
          w_qreq_nxt    = 1'b0;
          w_state_nxt   = ST_HOLD;
          w_hold_nxt    = C_HOLD_LOAD;
          if (!quiesce_ack) w_err_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt - TMO_W'(1);
        end
      end

      default: begin
        w_rst_out_nxt = C_ALL_RST;
        w_qreq_nxt    = 1'b0;
        w_state_nxt   = ST_HOLD;
        w_hold_nxt    = C_HOLD_LOAD;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_HOLD;
      r_hold    <= C_HOLD_LOAD;
      r_idx     <= '0;
      r_dcnt    <= '0;
      r_tcnt    <= '0;
      r_rst_out <= C_ALL_RST;
      r_qreq    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_idx     <= w_idx_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_qreq    <= w_qreq_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= (w_state_nxt != ST_RUN);
      r_done    <= (w_state_nxt == ST_RUN);
    end
  end

  assign quiesce_req = r_qreq;
  assign rst_out     = r_rst_out;
  assign seq_busy    = r_busy;
  assign seq_done    = r_done;
  assign qtmo_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cr_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_reset_sequencer
// Brief    : Directed self-checking bench for cr_reset_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_reset_sequencer;

  logic        clk;
  logic        rst;
  logic        soft_rst_req;
  logic [31:0] cfg_dly;
  logic        quiesce_req;
  logic        quiesce_ack;
  logic [3:0]  rst_out;
  logic        seq_busy;
  logic        seq_done;
  logic        qtmo_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic qreq_seen;

  cr_reset_sequencer #(
    .NUM_DOM  (4),
    .DLY_W    (8),
    .MIN_HOLD (16),
    .QTMO     (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .cfg_dly      (cfg_dly),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .rst_out      (rst_out),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .qtmo_err     (qtmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remembers any quiesce_req pulse since last cleared.
  always @(posedge clk) if (quiesce_req) qreq_seen <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges until rst_out changes, then check the gap and new value.
  task automatic step(input string tag, input int exp_cyc, input logic [3:0] exp_val);
    logic [3:0] prev;
    int cyc;
    prev = rst_out;
    cyc  = 0;
    do begin
      tick();
      cyc++;
    end while (rst_out === prev && cyc < 1000);
    check({tag, "_cyc"}, cyc, exp_cyc);
    check({tag, "_val"}, {28'd0, rst_out}, {28'd0, exp_val});
  endtask

  // Count edges until quiesce_req rises.
  task automatic wait_qreq(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (quiesce_req !== 1'b1 && cyc < 1000);
    check(tag, cyc, exp_cyc);
  endtask

  // Full staggered release from HOLD entry: gaps 21 (16 hold + 1 + 4), 1, 6, 2.
  task automatic release_seq(input string tag);
    step({tag, "_d0"}, 21, 4'b1110);
    step({tag, "_d1"}, 1,  4'b1100);
    step({tag, "_d2"}, 6,  4'b1000);
    check({tag, "_done_early"}, {31'd0, seq_done}, 32'd0);
    step({tag, "_d3"}, 2,  4'b0000);
    check({tag, "_done"}, {31'd0, seq_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    quiesce_ack  = 1'b0;
    qreq_seen    = 1'b0;
    cfg_dly      = {8'd1, 8'd5, 8'd0, 8'd3};

    // Reset values
    repeat (3) tick();
    check("rst_rst_out", {28'd0, rst_out}, 32'hF);
    check("rst_busy",    {31'd0, seq_busy},    32'd1);
    check("rst_done",    {31'd0, seq_done},    32'd0);
    check("rst_qreq",    {31'd0, quiesce_req}, 32'd0);
    check("rst_err",     {31'd0, qtmo_err},    32'd0);

    // Power-up release
    rst = 1'b0;
    release_seq("pu");

    // Clean soft reset with ack 5 cycles after quiesce_req
    soft_rst_req = 1'b1;
    wait_qreq("clean_qreq_lat", 3);
    check("clean_rst_during_q", {28'd0, rst_out}, 32'h0);
    repeat (4) tick();
    check("clean_qreq_held", {31'd0, quiesce_req}, 32'd1);
    quiesce_ack = 1'b1;
    step("clean_assert", 1, 4'b1111);
    check("clean_qreq_clr", {31'd0, quiesce_req}, 32'd0);
    check("clean_err",      {31'd0, qtmo_err},    32'd0);
    check("clean_busy",     {31'd0, seq_busy},    32'd1);
    quiesce_ack  = 1'b0;
    soft_rst_req = 1'b0;
    release_seq("clean_rel");

    // Timeout: no ack; request dropped mid-quiesce must still complete
    soft_rst_req = 1'b1;
    wait_qreq("tmo_qreq_lat", 3);
    soft_rst_req = 1'b0;
    step("tmo_assert", 256, 4'b1111);
    check("tmo_err",      {31'd0, qtmo_err},    32'd1);
    check("tmo_qreq_clr", {31'd0, quiesce_req}, 32'd0);
    release_seq("tmo_rel");
    check("tmo_err_sticky", {31'd0, qtmo_err}, 32'd1);

    // Abort during RELEASE at 1100
    soft_rst_req = 1'b1;
    wait_qreq("ab_qreq_lat", 3);
    quiesce_ack = 1'b1;
    step("ab_assert", 1, 4'b1111);
    quiesce_ack  = 1'b0;
    soft_rst_req = 1'b0;
    step("ab_d0", 21, 4'b1110);
    step("ab_d1", 1,  4'b1100);
    qreq_seen    = 1'b0;
    soft_rst_req = 1'b1;
    step("ab_abort", 3, 4'b1111);
    check("ab_busy", {31'd0, seq_busy}, 32'd1);
    soft_rst_req = 1'b0;
    release_seq("ab_rel");
    check("ab_no_qreq", {31'd0, qreq_seen}, 32'd0);

    // Async rst mid-RELEASE
    soft_rst_req = 1'b1;
    wait_qreq("ar1_qreq_lat", 3);
    quiesce_ack = 1'b1;
    step("ar1_assert", 1, 4'b1111);
    quiesce_ack  = 1'b0;
    soft_rst_req = 1'b0;
    step("ar1_d0", 21, 4'b1110);
    rst = 1'b1;
    #1;
    check("ar1_rst_out", {28'd0, rst_out}, 32'hF);
    check("ar1_busy",    {31'd0, seq_busy}, 32'd1);
    check("ar1_err_clr", {31'd0, qtmo_err}, 32'd0);
    #1;
    rst = 1'b0;
    release_seq("ar1_rel");

    // Ack coincides with the final timeout cycle: ack wins
    soft_rst_req = 1'b1;
    wait_qreq("sim_qreq_lat", 3);
    soft_rst_req = 1'b0;
    repeat (255) tick();
    check("sim_still_q", {28'd0, rst_out}, 32'h0);
    quiesce_ack = 1'b1;
    step("sim_assert", 1, 4'b1111);
    check("sim_err", {31'd0, qtmo_err}, 32'd0);
    quiesce_ack = 1'b0;
    release_seq("sim_rel");

    // Async rst mid-QUIESCE
    soft_rst_req = 1'b1;
    wait_qreq("ar2_qreq_lat", 3);
    repeat (10) tick();
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    #1;
    check("ar2_rst_out", {28'd0, rst_out}, 32'hF);
    check("ar2_qreq",    {31'd0, quiesce_req}, 32'd0);
    check("ar2_done",    {31'd0, seq_done}, 32'd0);
    #1;
    rst = 1'b0;
    release_seq("ar2_rel");
    check("ar2_err", {31'd0, qtmo_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cr_reset_sequencer.md
# cr_reset_sequencer

Single-clock reset sequencer for a group of datapath sub-domains. It synchronizes an asynchronous soft-reset request through a two-flop stage. On request assertion it quiesces traffic with a bounded-wait handshake, then asserts all domain resets together. On request release it deasserts the domain resets one at a time, in index order, with a per-domain programmable gap. It sits between the top-level reset/CSR logic and the per-engine reset inputs.

## Interface
- NUM_DOM, 4, number of sequenced domains (1..16)
- DLY_W, 8, width of each per-domain release delay
- MIN_HOLD, 16, minimum cycles all resets stay asserted before release may begin (≥1)
- QTMO, 255, maximum cycles to wait for quiesce_ack (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high block reset
- soft_rst_req  in  1  async soft-reset request, level, 1 = hold domains in reset
- cfg_dly  in  NUM_DOM*DLY_W  release gap for domain i at bits [i*DLY_W +: DLY_W], quasi-static
- quiesce_req  out  1  request to upstream to drain and stop traffic
- quiesce_ack  in  1  upstream drained, level
- rst_out  out  NUM_DOM  per-domain reset, active-high
- seq_busy  out  1  state is QUIESCE, HOLD or RELEASE
- seq_done  out  1  state is RUN, all domains out of reset
- qtmo_err  out  1  sticky, quiesce wait timed out

## Operation
- Reset values while rst = 1: state HOLD, rst_out all 1, quiesce_req 0, seq_busy 1, seq_done 0, qtmo_err 0, hold counter MIN_HOLD, sync flops 0.
- States are HOLD, RELEASE, RUN, QUIESCE. req_s is the synchronized soft_rst_req.
- HOLD: rst_out all 1. The hold counter decrements to 0 and saturates there. When the counter is 0 and req_s = 0, go to RELEASE with idx = 0 and dcnt = cfg_dly[0].
- RELEASE: each cycle, if dcnt = 0, clear rst_out[idx]. If idx < NUM_DOM-1, increment idx and load dcnt = cfg_dly[idx+1]; otherwise go to RUN. If dcnt ≠ 0, decrement dcnt. If req_s = 1 in RELEASE, abort: set all rst_out to 1, go to HOLD, and reload the hold counter to MIN_HOLD. No quiesce is done on abort. Abort has priority over a same-cycle release.
- RUN: rst_out all 0. When req_s = 1, go to QUIESCE, set quiesce_req = 1, and load the timeout counter with QTMO.
- QUIESCE: on quiesce_ack = 1, or when the timeout counter reaches 0 (which sets qtmo_err), set all rst_out to 1, clear quiesce_req, go to HOLD, and reload the hold counter. If ack and timeout occur in the same cycle, ack wins and qtmo_err is not set. If req_s drops during QUIESCE, the block still completes the assertion and is never left half-quiesced.
- qtmo_err is cleared only by rst.
- cfg_dly is sampled only at dcnt load. A cfg_dly value of 0 releases the domain on the cycle after the load.

## Timing
- soft_rst_req to req_s takes 2 clk edges.
- RELEASE entry is 1 cycle after req_s = 0 is seen in HOLD with the hold count done.
- rst_out[0] falls cfg_dly[0]+1 cycles after RELEASE entry. rst_out[i] falls cfg_dly[i]+1 cycles after rst_out[i-1].
- seq_done rises in the same cycle that rst_out[NUM_DOM-1] falls.
- quiesce_req rises 1 cycle after req_s = 1 is seen in RUN.
- rst_out rises 1 cycle after quiesce_ack is sampled high. In the no-ack case, it rises QTMO+1 cycles after quiesce_req rises.
- All outputs are registered; there are no combinational input-to-output paths.
- rst asserted mid-sequence forces the reset values immediately, asynchronously.

## Structure
- Package cr_reset_seq_pkg holds:
  - the state enum (HOLD, RELEASE, RUN, QUIESCE);
  - an index width localparam derived as clog2(NUM_DOM), with a minimum of 1.
- Sub-module cr_reset_seq_sync: a two-flop, active-high async-reset synchronizer with reset value 0. It is instantiated once for soft_rst_req.
- The FSM, hold counter, delay counter and timeout counter live in the top module.

## Test plan
- Power-up: NUM_DOM=4, cfg_dly={3,0,5,1} for domains 0..3, soft_rst_req=0, rst released.
  - After MIN_HOLD=16 cycles plus sync latency, rst_out steps 1111→1110→1100→1000→0000.
  - Gaps are 4, 1, 6 and 2 cycles; seq_done rises with the last step.
- Clean soft reset: in RUN, assert soft_rst_req and return quiesce_ack 5 cycles after quiesce_req rises.
  - rst_out goes to 1111 one cycle after ack; qtmo_err stays 0.
- Timeout: in RUN, assert soft_rst_req and never ack, with QTMO=255.
  - rst_out goes to 1111 after 256 cycles of quiesce_req; qtmo_err = 1 and stays 1 after a subsequent release sequence.
- Abort: reassert soft_rst_req while rst_out=1100 in RELEASE.
  - rst_out returns to 1111 with no quiesce_req pulse; a later release restarts from domain 0 after the full MIN_HOLD.
- Simultaneous ack and timeout in the same cycle → rst_out asserts and qtmo_err = 0.
- Async rst pulse mid-RELEASE, and separately mid-QUIESCE → outputs take their reset values without waiting for a clk edge, and the full sequence replays.
